// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, frame constants and baud divisor helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  localparam logic IDLE_LVL = 1'b1;

  // Clocks per line bit; baudrate_gen uses the same integer division
  function automatic int divisor(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO with push/pop, full/empty and occupancy count
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;

  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;

  // Storage needs no reset; only pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointers wrap naturally at AW bits since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first UART transmitter fed from a byte FIFO
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = divisor(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] head;
  logic [AW:0] count;
  logic tx_n, pop, full, empty, bit_end;

  assign tx_ready = !full;
  assign busy = state != IDLE || count != '0;
  assign bit_end = cnt == CW'(DIV-1);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tx_valid),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );

  // Next state; tx is computed from the next state so the line is registered yet has no extra lag
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
    bit_n = bit_cnt;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_n = head;
        bit_n = '0;
        state_n = START;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_n = bit_cnt + BW'(1);
        if (bit_cnt == BW'(DATA_BITS-1)) state_n = STOP;
      end
      STOP: if (bit_end) begin
        pop = !empty;
        shift_n = empty ? shift : head;
        bit_n = '0;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? START_LVL :
           state_n == DATA  ? shift_n[0] :
           state_n == STOP  ? STOP_LVL : IDLE_LVL;
  end

  // State, counters, shift register and the registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= IDLE_LVL;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench decoding the serial line and checking frame timing
module tb_uart_tx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, tx, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decodes every frame on the line and checks it against the queued bytes
  task automatic monitor();
    logic [7:0] d, e;
    logic first, ok, ab;
    int s;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        s = cyc;
        ok = 1'b1;
        ab = 1'b0;
        d = 8'h00;
        first = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int j = 0; j < DIV; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (rst) ab = 1'b1;
            if (j == 0) first = tx;
            else if (tx !== first) ok = 1'b0;
            if (j == 0 && k >= 1 && k <= 8) d[k-1] = tx;
            if (j == 0 && k == 9 && tx !== 1'b1) ok = 1'b0;
          end
        end
        if (!ab) begin
          starts.push_back(s);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame_unexpected: got byte %h at cycle %0d, none queued", d, s);
          end else begin
            e = exp_q.pop_front();
            if (!ok || d !== e) begin
              n_fail++;
              $display("FAIL frame: got %h (bit timing ok=%0b) at cycle %0d, expected %h", d, ok, s, e);
            end
          end
        end
      end
    end
  endtask

  // Presents one byte for one edge; returns acceptance and cycle number after the edge
  task automatic drive(input logic [7:0] b, output logic acc, output int ec);
    tx_data = b;
    tx_valid = 1'b1;
    acc = tx_ready;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    ec = cyc;
    tx_valid = 1'b0;
  endtask

  // Counts cycles until busy drops, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_spacing(input string name, input int nf);
    int bad = 0;
    n_checks++;
    if (starts.size() != nf) begin
      n_fail++;
      $display("FAIL %s_frames: got %0d frames, expected %0d", name, starts.size(), nf);
    end else begin
      for (int i = 1; i < nf; i++) if (starts[i] - starts[i-1] != FRAME) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL %s_spacing: %0d gaps differ from %0d cycles", name, bad, FRAME);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes never seen, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic acc;
    int e, n;
    starts.delete();
    drive(8'hA5, acc, e);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", acc); end
    @(negedge clk);
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL single_latency: tx %b one edge after accept, expected 0", tx); end
    wait_idle(n);
    n_checks++;
    if (n != FRAME) begin n_fail++; $display("FAIL single_busy: busy lasted %0d cycles after start, expected %0d", n, FRAME); end
    n_checks++;
    if (starts.size() != 1 || starts[0] != e + 1) begin
      n_fail++;
      $display("FAIL single_start: %0d frames, first at %0d, expected 1 at %0d", starts.size(), starts.size() ? starts[0] : -1, e + 1);
    end
    check_spacing("single", 1);
  endtask

  task automatic test_back_to_back();
    logic a1, a2;
    int e1, e2, n;
    starts.delete();
    drive(8'h3C, a1, e1);
    drive(8'h12, a2, e2);
    n_checks++;
    if (!(a1 && a2)) begin n_fail++; $display("FAIL b2b_accept: got %b%b expected 11", a1, a2); end
    wait_idle(n);
    n_checks++;
    if (n != 2 * FRAME) begin n_fail++; $display("FAIL b2b_busy: busy lasted %0d cycles, expected %0d", n, 2 * FRAME); end
    check_spacing("b2b", 2);
  endtask

  task automatic test_push_pop();
    logic a, b, c;
    int ea, eb, ec, g, n;
    starts.delete();
    drive(8'h5A, a, ea);
    drive(8'hC3, b, eb);
    g = 0;
    while (cyc != ea + FRAME && g < 2 * FRAME) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_ready: got %b expected 1", tx_ready); end
    drive(8'h81, c, ec);
    n_checks++;
    if (!(a && b && c)) begin n_fail++; $display("FAIL pushpop_accept: got %b%b%b expected 111", a, b, c); end
    wait_idle(n);
    check_spacing("pushpop", 3);
  endtask

  task automatic test_fill();
    int acc_n = 0, e0 = -1, g = 0, rise, n;
    starts.delete();
    while (tx_ready && g < 40) begin
      tx_data = acc_n[7:0];
      tx_valid = 1'b1;
      exp_q.push_back(acc_n[7:0]);
      acc_n++;
      @(negedge clk);
      if (e0 < 0) e0 = cyc;
      g++;
    end
    n_checks++;
    if (acc_n != 9) begin n_fail++; $display("FAIL fill_count: accepted %0d before tx_ready fell, expected 9", acc_n); end
    tx_data = acc_n[7:0];
    g = 0;
    while (!tx_ready && g < 2 * FRAME) begin
      @(negedge clk);
      g++;
    end
    rise = cyc;
    n_checks++;
    if (rise != e0 + 1 + FRAME) begin n_fail++; $display("FAIL fill_ready_rise: at cycle %0d, expected %0d", rise, e0 + 1 + FRAME); end
    exp_q.push_back(acc_n[7:0]);
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(n);
    check_spacing("fill", 10);
  endtask

  task automatic test_reset_mid();
    logic a;
    int e, e2, g = 0, bad = 0;
    starts.delete();
    drive(8'hF7, a, e);
    drive(8'h11, a, e2);
    drive(8'h22, a, e2);
    drive(8'h33, a, e2);
    while (cyc != e + 1 + 4 * DIV + DIV / 2 && g < 2 * FRAME) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3: tx %b before reset, expected 0", tx); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", tx_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || starts.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: %0d active cycles, %0d frames after release, expected 0 and 0", bad, starts.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_push_pop();
    test_fill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, 8N1, LSB first, idle-high line: the transmit counterpart of the existing UART receiver. Bytes are written through a valid/ready port into an internal FIFO, and the block serialises them onto `tx` at `BAUD_RATE` using a bit-period counter on the single system clock. It sits between the host-side logic and the board TX pin, and is the stimulus source for loopback tests of the receiver.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 8: byte FIFO depth; must be a power of two and ≥ 2.
- Derived `DIV` = `CLK_FREQ/BAUD_RATE`, integer division (868 at defaults); must be ≥ 2.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: FIFO can accept a byte; equals `!full`.
- `tx`, out, 1: serial line; registered output.
- `busy`, out, 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- **Accept:** a byte is accepted on a rising edge where `tx_valid && tx_ready`. `tx_valid` while `tx_ready` is low is ignored; nothing is dropped silently and `tx_data` need not be held.
- **FIFO:** push on accept and pop on load. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the 8-bit shift register, clear the bit counter, and go to START.
  - START: `tx`=0 for `DIV` clocks, then go to DATA.
  - DATA: `tx`=shift[0] for `DIV` clocks per bit, shifting right after each bit. Go to STOP after 8 bits (3-bit counter reaches 7).
  - STOP: `tx`=1 for `DIV` clocks. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- **Baud counter:** counts 0..`DIV`-1 and reloads to 0 on each bit boundary. It is held at 0 in IDLE.
- **Reset values:** `tx`=1, `tx_ready`=1, `busy`=0, FIFO empty, FSM in IDLE, counters 0.
- **Reset mid-frame:** `tx` returns to 1 immediately (asynchronous) and queued bytes are discarded. The partial frame is allowed to appear as a framing error at the receiver.

## Timing
- Latency: a byte accepted on edge E into an empty FIFO while IDLE drives `tx` low from edge E+1.
- Every line bit lasts exactly `DIV` clocks. One frame is 10·`DIV` clocks (8680 at defaults).
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit clock. N queued bytes occupy exactly N·10·`DIV` clocks.
- `tx_ready` falls on the edge the FIFO becomes full and rises on the edge of the next pop.
- Capacity: the shift register plus the FIFO hold at most `FIFO_DEPTH`+1 bytes in flight.
- `busy` deasserts on the edge the FSM enters IDLE with the FIFO empty.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - Frame constants: `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1, `IDLE_LVL`=1.
  - A `divisor(clk_freq, baud)` function. It must match the divisor used by `baudrate_gen`.
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO with push/pop/full/empty/count and asynchronous reset.
- `uart_tx` itself contains the FSM, baud counter, bit counter, and shift register.

## Test plan
- **Single byte:** reset, then write 0xA5 once. `tx` must be low on the next edge, then show bits 1,0,1,0,0,1,0,1 and stop=1. Each bit lasts 868 clocks, 8680 total, and `busy` is low afterwards.
- **Back-to-back:** write 0x3C and 0x12 on consecutive cycles. The second start bit must begin exactly 8680 clocks after the first one. `busy` stays high for 17360 clocks with no idle gap.
- **Fill and backpressure:** hold `tx_valid`=1 with an incrementing byte from 0x00. Exactly 9 bytes are accepted before `tx_ready`=0. `tx_ready` returns to 1 one edge after the frame-8680 boundary pop, and the line order is 0x00…0x08.
- **Push/pop same cycle:** with one byte queued, push on the pop edge. The count is unchanged and no byte is lost or duplicated.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 3 bytes queued. `tx`=1 asynchronously, `tx_ready`=1, `busy`=0, and there is no further line activity after release.
- **Loopback:** drive `tx` into the UART receiver (clocked by `baudrate_gen`) and send 0xA5, 0x3C, 0x12 with random gaps. The receiver's `en` pulses three times, with `data_out` = 0xA5, 0x3C, 0x12 in order.
